// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, keyboard command bytes and 25 MHz timing defaults.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, WAIT_DEV, SHIFT, ACK, WAIT_IDLE, FAIL} state_t;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK_BYTE = 8'hFA;
  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_START_TIMEOUT = 375000;
  localparam int DEF_PACKET_TIMEOUT = 50000;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes the PS/2 clock and data lines and flags one-cycle clock falling edges.
//   clk, rst     system clock, synchronous active-high reset
//   clk_i/data_i asynchronous line levels
//   clk_s/data_s synchronized levels; fall = synced clock went 1->0
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [STAGES-1:0] cs, ds;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= '1;
      ds <= '1;
      prev <= 1'b1;
    end else begin
      cs <= {cs[STAGES-2:0], clk_i};
      ds <= {ds[STAGES-2:0], data_i};
      prev <= cs[STAGES-1];
    end
  end
  assign clk_s = cs[STAGES-1];
  assign data_s = ds[STAGES-1];
  assign fall = prev & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving the lines open-drain via output enables.
//   CLK_25MHZ, RESET          system clock, synchronous active-high reset
//   PS2_CLK_I, PS2_DATA_I     raw line levels
//   PS2_CLK_OE, PS2_DATA_OE   1 pulls the line low
//   TX_VALID/TX_DATA/TX_READY command byte handshake
//   BUSY                      transaction in progress (receiver ignores the lines)
//   TX_DONE, TX_ERROR         one-cycle completion / failure pulses
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK_I,
  input  logic       PS2_DATA_I,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic       TX_ERROR
);
  localparam int CW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, PACKET_TIMEOUT)) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] PKT_LAST = CW'(PACKET_TIMEOUT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bits, bits_n;
  logic [8:0] sr, sr_n;
  logic data_oe, data_oe_n;
  logic clk_s, data_s, fall, wd, idle_lines;
  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(CLK_25MHZ), .rst(RESET), .clk_i(PS2_CLK_I), .data_i(PS2_DATA_I),
    .clk_s(clk_s), .data_s(data_s), .fall(fall)
  );
  assign wd = cnt == PKT_LAST;
  assign idle_lines = clk_s & data_s;
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      sr <= '0;
      data_oe <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bits <= bits_n;
      sr <= sr_n;
      data_oe <= data_oe_n;
    end
  end
  // One counter serves inhibit timing, start timeout and packet watchdog; it is cleared at each phase change.
  always_comb begin
    state_n = state;
    cnt_n = &cnt ? cnt : cnt + 1'b1;
    bits_n = bits;
    sr_n = sr;
    data_oe_n = data_oe;
    case (state)
      IDLE: begin
        cnt_n = '0;
        data_oe_n = 1'b0;
        if (TX_VALID) begin
          sr_n = {~^TX_DATA, TX_DATA};
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        // Start bit overlaps the last inhibit cycle so DATA is low before CLK is released.
        if (data_oe) begin
          state_n = WAIT_DEV;
          cnt_n = '0;
        end else if (cnt == INH_LAST) data_oe_n = 1'b1;
      end
      WAIT_DEV: begin
        if (fall) begin
          data_oe_n = ~sr[0];
          sr_n = sr >> 1;
          bits_n = 4'd1;
          cnt_n = '0;
          state_n = SHIFT;
        end else if (cnt == START_LAST) begin
          data_oe_n = 1'b0;
          state_n = FAIL;
        end
      end
      SHIFT: begin
        if (wd) begin
          data_oe_n = 1'b0;
          state_n = FAIL;
        end else if (fall) begin
          bits_n = bits + 1'b1;
          data_oe_n = bits == 4'd9 ? 1'b0 : ~sr[0];
          sr_n = sr >> 1;
          state_n = bits == 4'd9 ? ACK : SHIFT;
        end
      end
      ACK: state_n = wd ? FAIL : fall ? (data_s ? FAIL : WAIT_IDLE) : ACK;
      WAIT_IDLE: state_n = idle_lines ? IDLE : wd ? FAIL : WAIT_IDLE;
      FAIL: begin
        data_oe_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign PS2_CLK_OE = state == INHIBIT;
  assign PS2_DATA_OE = data_oe;
  assign TX_READY = state == IDLE;
  assign BUSY = state != IDLE;
  assign TX_DONE = state == WAIT_IDLE && idle_lines;
  assign TX_ERROR = state == FAIL;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk, ps2_data, clk_oe, data_oe, tx_ready, busy, tx_done, tx_error;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, hs_cnt = 0, hs_at_done = 0;
  assign ps2_clk = ~(clk_oe | dev_clk_low);
  assign ps2_data = ~(data_oe | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(8), .START_TIMEOUT(200), .PACKET_TIMEOUT(2000), .SYNC_STAGES(2)) dut (
    .CLK_25MHZ(clk), .RESET(rst), .PS2_CLK_I(ps2_clk), .PS2_DATA_I(ps2_data),
    .PS2_CLK_OE(clk_oe), .PS2_DATA_OE(data_oe), .TX_VALID(tx_valid), .TX_DATA(tx_data),
    .TX_READY(tx_ready), .BUSY(busy), .TX_DONE(tx_done), .TX_ERROR(tx_error)
  );
  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      hs_at_done = hs_cnt;
    end
    if (tx_error) err_cnt++;
    if (tx_valid && tx_ready) hs_cnt++;
  end
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = b;
    @(posedge clk); #1 tx_valid = 1'b0;
  endtask
  // Device: waits for request-to-send, clocks 'edges' falling edges (20-cycle half period), captures
  // DATA at the end of each low phase, and pulls DATA low before the 11th edge when ack is set.
  task automatic dev_clock(input int edges, input bit ack, output logic [9:0] cap);
    int n = 0;
    cap = '0;
    while (!(ps2_clk && !ps2_data) && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n >= 1000) begin errors++; $display("FAIL rts_wait: waited %0d cycles, required < 1000", n); end
    for (int i = 0; i < edges; i++) begin
      if (i == 10) dev_data_low = ack;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (i < 10) cap[i] = ps2_data;
      dev_clk_low = 1'b0;
    end
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
    repeat (20) @(negedge clk);
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
    checks++; if (!tx_ready) begin errors++; $display("FAIL ready_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b, expected 0", clk_oe); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b, expected 0", data_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", tx_done); end
    checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, expected 0", tx_error); end
    rst = 1'b0;
  endtask
  task automatic test_set_leds();
    int n = 0, d0 = done_cnt, e0 = err_cnt;
    logic [9:0] cap;
    send(CMD_SET_LEDS);
    @(negedge clk);
    while (clk_oe && !data_oe && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 8) begin errors++; $display("FAIL inhibit_len: got %0d cycles, expected 8", n); end
    checks++; if ({clk_oe, data_oe} !== 2'b11) begin errors++; $display("FAIL start_bit: clk_oe,data_oe got %b, expected 11", {clk_oe, data_oe}); end
    @(negedge clk);
    checks++; if ({clk_oe, data_oe} !== 2'b01) begin errors++; $display("FAIL clk_release: clk_oe,data_oe got %b, expected 01", {clk_oe, data_oe}); end
    dev_clock(11, 1'b1, cap);
    wait_ready();
    checks++; if (cap !== 10'b1_1_11101101) begin errors++; $display("FAIL leds_frame: got %b, expected 1111101101", cap); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL leds_done: got %0d pulses, expected 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL leds_error: got %0d pulses, expected 0", err_cnt - e0); end
  endtask
  task automatic test_parity();
    logic [7:0] bs [2] = '{8'h01, 8'h00};
    logic [9:0] exp_cap [2] = '{10'b1_0_00000001, 10'b1_1_00000000};
    logic [9:0] cap;
    for (int i = 0; i < 2; i++) begin
      int d0 = done_cnt;
      send(bs[i]);
      dev_clock(11, 1'b1, cap);
      wait_ready();
      checks++; if (cap !== exp_cap[i]) begin errors++; $display("FAIL parity_frame_%h: got %b, expected %b", bs[i], cap, exp_cap[i]); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL parity_done_%h: got %0d pulses, expected 1", bs[i], done_cnt - d0); end
    end
  endtask
  task automatic test_no_clock();
    int n = 0, d0 = done_cnt, e0 = err_cnt;
    send(CMD_ENABLE);
    @(negedge clk);
    while (clk_oe && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_error && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n != 200) begin errors++; $display("FAIL start_timeout: error after %0d cycles, expected 200", n); end
    checks++; if ({clk_oe, data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_oe: got %b, expected 00", {clk_oe, data_oe}); end
    @(negedge clk);
    checks++; if ({tx_ready, tx_error} !== 2'b10) begin errors++; $display("FAIL timeout_ready: ready,error got %b, expected 10", {tx_ready, tx_error}); end
    checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin errors++; $display("FAIL timeout_pulses: error %0d done %0d, expected 1 and 0", err_cnt - e0, done_cnt - d0); end
  endtask
  task automatic test_no_ack();
    int d0 = done_cnt, e0 = err_cnt;
    logic [9:0] cap;
    send(CMD_ENABLE);
    dev_clock(11, 1'b0, cap);
    wait_ready();
    checks++; if (cap !== 10'b1_0_11110100) begin errors++; $display("FAIL noack_frame: got %b, expected 1011110100", cap); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL noack_error: got %0d pulses, expected 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL noack_done: got %0d pulses, expected 0", done_cnt - d0); end
  endtask
  task automatic test_reset_mid();
    int d0 = done_cnt, e0 = err_cnt;
    logic [9:0] cap;
    send(8'hAA);
    dev_clock(4, 1'b0, cap);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, expected 1", busy); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({clk_oe, data_oe, busy, tx_ready} !== 4'b0001) begin errors++; $display("FAIL mid_reset: oe,oe,busy,ready got %b, expected 0001", {clk_oe, data_oe, busy, tx_ready}); end
    rst = 1'b0;
    checks++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin errors++; $display("FAIL mid_pulses: done %0d error %0d, expected 0 and 0", done_cnt - d0, err_cnt - e0); end
    send(CMD_RESET);
    dev_clock(11, 1'b1, cap);
    wait_ready();
    checks++; if (cap !== 10'b1_1_11111111) begin errors++; $display("FAIL after_reset_frame: got %b, expected 1111111111", cap); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL after_reset_done: got %0d pulses, expected 1", done_cnt - d0); end
  endtask
  task automatic test_back_to_back();
    int d0 = done_cnt, h0 = hs_cnt;
    logic [9:0] cap;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h12;
    @(posedge clk); #1 tx_data = 8'h34;
    fork
      dev_clock(11, 1'b1, cap);
      begin repeat (150) @(posedge clk); #1 tx_data = 8'h56; end
    join
    checks++; if (cap !== 10'b1_1_00010010) begin errors++; $display("FAIL hold_frame: got %b, expected 1100010010", cap); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL hold_done: got %0d pulses, expected 1", done_cnt - d0); end
    checks++; if (hs_at_done - h0 != 1) begin errors++; $display("FAIL hold_hs_at_done: got %0d handshakes, expected 1", hs_at_done - h0); end
    checks++; if (hs_cnt - h0 != 2) begin errors++; $display("FAIL hold_second_hs: got %0d handshakes, expected 2", hs_cnt - h0); end
    tx_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_set_leds();
    test_parity();
    test_no_clock();
    test_no_ack();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
